// File: rtl/vp_fb_writer.sv
// Frame-buffer writer: pops pixels from the upstream FIFO and writes them into a
// ping-pong frame buffer, handling line/frame counting, bank swap, drop and resync.
module vp_fb_writer #(
    parameter int unsigned DW = 12,
    parameter int unsigned RL = 640,
    parameter int unsigned NL = 480,
    parameter int unsigned AW = 19
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_data_valid,
    output logic          o_data_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_frame_sync,
    input  logic          i_hold,
    output logic          o_wr_en,
    output logic [AW:0]   o_wr_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_front_bank,
    output logic          o_frame_done,
    output logic          o_frame_drop,
    output logic [15:0]   o_frame_cnt
);

    localparam int unsigned XW = (RL > 1) ? $clog2(RL) : 1;
    localparam int unsigned YW = (NL > 1) ? $clog2(NL) : 1;

    // POP: ready is visible, FIFO pops at the end of this cycle.
    // CAPT: popped data is on i_data and is registered into the write port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            wr_en_q, wr_en_d;
    logic [AW:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            front_q, front_d;
    logic            bank_q, bank_d;
    logic            done_q, done_d;
    logic            drop_q, drop_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW:0]     pend_addr_q, pend_addr_d;
    logic            pend_eof_q, pend_eof_d;

    logic            x_last, y_last;

    assign x_last = (x_q == XW'(RL - 1));
    assign y_last = (y_q == YW'(NL - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            front_q     <= 1'b0;
            bank_q      <= 1'b1;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            idx_q       <= '0;
            pend_addr_q <= '0;
            pend_eof_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            front_q     <= front_d;
            bank_q      <= bank_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            idx_q       <= idx_d;
            pend_addr_q <= pend_addr_d;
            pend_eof_q  <= pend_eof_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        front_d     = front_q;
        bank_d      = bank_q;
        done_d      = 1'b0;
        drop_d      = 1'b0;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        idx_d       = idx_q;
        pend_addr_d = pend_addr_q;
        pend_eof_d  = pend_eof_q;

        case (state_q)
            IDLE: begin
                if (i_data_valid) begin
                    ready_d = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                // Address is bound at pop time so a later sync cannot move this pixel.
                pend_addr_d = {bank_q, idx_q};
                pend_eof_d  = x_last && y_last;
                if (x_last) begin
                    x_d = '0;
                    if (y_last) begin
                        y_d   = '0;
                        idx_d = '0;
                    end else begin
                        y_d   = y_q + YW'(1);
                        idx_d = idx_q + AW'(1);
                    end
                end else begin
                    x_d   = x_q + XW'(1);
                    idx_d = idx_q + AW'(1);
                end
                state_d = CAPT;
            end
            CAPT: begin
                wr_en_d   = 1'b1;
                wr_data_d = i_data;
                wr_addr_d = pend_addr_q;
                if (pend_eof_q) begin
                    done_d = 1'b1;
                    if (i_hold) begin
                        drop_d = 1'b1;
                    end else begin
                        front_d = bank_q;
                        bank_d  = ~bank_q;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
                if (i_data_valid) begin
                    ready_d = 1'b1;
                    state_d = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_frame_sync) begin
            x_d   = '0;
            y_d   = '0;
            idx_d = '0;
        end
    end

    assign o_data_ready = ready_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_front_bank = front_q;
    assign o_frame_done = done_q;
    assign o_frame_drop = drop_q;
    assign o_frame_cnt  = cnt_q;

endmodule

// File: tb/tb_vp_fb_writer.sv
// Directed bench for vp_fb_writer on a small 8x4 frame with a FIFO-like source.
module tb_vp_fb_writer;

    localparam int unsigned DW = 12;
    localparam int unsigned RL = 8;
    localparam int unsigned NL = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned NPIX = RL * NL;
    localparam int unsigned B1 = 1 << AW;

    logic          clk;
    logic          rst;
    logic          i_data_valid;
    logic          o_data_ready;
    logic [DW-1:0] i_data;
    logic          i_frame_sync;
    logic          i_hold;
    logic          o_wr_en;
    logic [AW:0]   o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_front_bank;
    logic          o_frame_done;
    logic          o_frame_drop;
    logic [15:0]   o_frame_cnt;

    vp_fb_writer #(.DW(DW), .RL(RL), .NL(NL), .AW(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .i_data       (i_data),
        .i_frame_sync (i_frame_sync),
        .i_hold       (i_hold),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_front_bank (o_front_bank),
        .o_frame_done (o_frame_done),
        .o_frame_drop (o_frame_drop),
        .o_frame_cnt  (o_frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int pops  = 0;
    int writes = 0;
    int src_val = 1;
    logic prev_rdy = 1'b0;
    int            pop_q[$];
    logic [DW-1:0] data_q[$];

    logic [AW:0]   w_addr;
    logic [DW-1:0] w_data;
    logic          w_done, w_drop, w_front;
    logic [15:0]   w_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next write and snapshot the outputs of that cycle.
    task automatic wait_wr();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_wr_en && n < 20);
        chk("wr_seen", 32'(o_wr_en), 32'd1);
        w_addr  = o_wr_addr;
        w_data  = o_wr_data;
        w_done  = o_frame_done;
        w_drop  = o_frame_drop;
        w_front = o_front_bank;
        w_cnt   = o_frame_cnt;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_data_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
        chk({tag, "_addr"},  32'(o_wr_addr), 32'd0);
        chk({tag, "_data"},  32'(o_wr_data), 32'd0);
        chk({tag, "_front"}, 32'(o_front_bank), 32'd0);
        chk({tag, "_done"},  32'(o_frame_done), 32'd0);
        chk({tag, "_drop"},  32'(o_frame_drop), 32'd0);
        chk({tag, "_cnt"},   32'(o_frame_cnt), 32'd0);
    endtask

    // FIFO model: data appears the cycle after a pop.
    initial begin
        forever begin
            @(negedge clk);
            if (o_data_ready) begin
                @(posedge clk);
                #1;
                i_data = DW'(src_val);
                data_q.push_back(DW'(src_val));
                src_val++;
            end
        end
    end

    // Handshake monitor: no back-to-back pops, every write preceded by a pop 2 cycles earlier.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rdy = 1'b0;
            end else begin
                if (o_data_ready) begin
                    chk("no_b2b", 32'(prev_rdy), 32'd0);
                    pop_q.push_back(cyc);
                    pops++;
                end
                if (o_wr_en) begin
                    chk("wr_has_pop", 32'(pop_q.size() != 0), 32'd1);
                    if (pop_q.size() != 0) chk("latency", 32'(cyc - pop_q.pop_front()), 32'd2);
                    chk("wr_data_avail", 32'(data_q.size() != 0), 32'd1);
                    if (data_q.size() != 0) chk("wr_data", 32'(o_wr_data), 32'(data_q.pop_front()));
                    writes++;
                end
                prev_rdy = o_data_ready;
            end
        end
    end

    initial begin
        rst = 1'b1;
        i_data_valid = 1'b0;
        i_data = '0;
        i_frame_sync = 1'b0;
        i_hold = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Frame 1 into bank 1, swap at end.
        i_data_valid = 1'b1;
        for (int i = 0; i < int'(NPIX); i++) begin
            wait_wr();
            chk("f1_addr", 32'(w_addr), 32'(B1 + i));
            chk("f1_data", 32'(w_data), 32'(i + 1));
            chk("f1_done", 32'(w_done), 32'(i == int'(NPIX) - 1));
            if (i == int'(NPIX) - 1) begin
                chk("f1_front", 32'(w_front), 32'd1);
                chk("f1_cnt", 32'(w_cnt), 32'd1);
                chk("f1_drop", 32'(w_drop), 32'd0);
            end
        end
        wait_wr();
        chk("f2_first_addr", 32'(w_addr), 32'd0);
        chk("f2_first_data", 32'(w_data), 32'(NPIX + 1));

        // Frame 2 into bank 0 with hold: dropped, bank reused.
        i_hold = 1'b1;
        for (int i = 1; i < int'(NPIX); i++) begin
            wait_wr();
            chk("f2_addr", 32'(w_addr), 32'(i));
            chk("f2_done", 32'(w_done), 32'(i == int'(NPIX) - 1));
            chk("f2_drop", 32'(w_drop), 32'(i == int'(NPIX) - 1));
        end
        chk("f2_front", 32'(w_front), 32'd1);
        chk("f2_cnt", 32'(w_cnt), 32'd1);
        wait_wr();
        i_hold = 1'b0;
        chk("f3_first_addr", 32'(w_addr), 32'd0);

        // Mid-frame sync while idle.
        for (int i = 1; i <= 10; i++) begin
            wait_wr();
            chk("f3_addr", 32'(w_addr), 32'(i));
        end
        i_data_valid = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1 i_frame_sync = 1'b1;
        @(posedge clk); #1 i_frame_sync = 1'b0;
        i_data_valid = 1'b1;
        wait_wr();
        chk("sync_addr", 32'(w_addr), 32'd0);
        chk("sync_done", 32'(w_done), 32'd0);
        chk("sync_drop", 32'(w_drop), 32'd0);
        chk("sync_front", 32'(w_front), 32'd1);

        // Sync while a capture is pending.
        for (int i = 1; i <= 3; i++) begin
            wait_wr();
            chk("pre_cs_addr", 32'(w_addr), 32'(i));
        end
        chk("cs_phase", 32'(o_data_ready), 32'd1);
        @(posedge clk); #1 i_frame_sync = 1'b1;
        @(posedge clk); #1 i_frame_sync = 1'b0;
        wait_wr();
        chk("cs_old_addr", 32'(w_addr), 32'd4);
        wait_wr();
        chk("cs_new_addr", 32'(w_addr), 32'd0);

        // Toggling valid: conservation of pixels.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1 i_data_valid = ~i_data_valid;
        end
        i_data_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pops_eq_writes", 32'(writes), 32'(pops));

        // Asynchronous reset mid-frame.
        i_data_valid = 1'b1;
        wait_wr();
        wait_wr();
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        pop_q.delete();
        data_q.delete();
        #6 rst = 1'b0;
        wait_wr();
        chk("arst_addr", 32'(w_addr), 32'(B1));
        chk("arst_front", 32'(w_front), 32'd0);
        chk("arst_cnt", 32'(w_cnt), 32'd0);
        i_data_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
